// File: rtl/sprite_line_renderer.sv
// rtl/sprite_line_renderer.sv - renders one line of sprites into a palette-index line buffer
module sprite_line_renderer #(
  parameter int OAM_ADDR_SIZE     = 8,
  parameter int OAM_DATA_SIZE     = 32,
  parameter int SECOND_ARRAY_SIZE = 32,
  parameter int SPRITE_WIDTH      = 16,
  parameter int SPRITE_HEIGHT     = 16,
  parameter int PIXEL_BITS        = 8,
  parameter int VRAM_ADDR_SIZE    = 8 + $clog2(SPRITE_HEIGHT),
  parameter int VRAM_DATA_SIZE    = SPRITE_WIDTH * PIXEL_BITS,
  parameter int DISPLAY_WIDTH     = 600,
  parameter int DISPLAY_HEIGHT    = 480,
  parameter int LINE_NUMBER_WIDTH = $clog2(DISPLAY_HEIGHT)
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              start,
  output logic                                              busy,
  output logic                                              done,
  input  logic [SECOND_ARRAY_SIZE-1:0][OAM_ADDR_SIZE:0]     second_array,
  input  logic [LINE_NUMBER_WIDTH-1:0]                      line_number,
  output logic                                              oam_rd,
  output logic [OAM_ADDR_SIZE-1:0]                          oam_a,
  input  logic [OAM_DATA_SIZE-1:0]                          oam_d,
  output logic                                              vram_rd,
  output logic [VRAM_ADDR_SIZE-1:0]                         vram_a,
  input  logic [VRAM_DATA_SIZE-1:0]                         vram_d,
  output logic [DISPLAY_WIDTH-1:0][PIXEL_BITS-1:0]          line_buffer,
  output logic [DISPLAY_WIDTH-1:0]                          line_prio
);

  localparam int SEL_W = $clog2(SECOND_ARRAY_SIZE);
  localparam int IDX_W = SEL_W + 1;
  localparam int ROW_W = $clog2(SPRITE_HEIGHT);
  localparam int XW    = $clog2(DISPLAY_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_OAM_REQ, S_OAM_LAT, S_VRAM_REQ, S_VRAM_LAT, S_DRAW, S_DONE
  } state_t;

  state_t                                   r_state;
  state_t                                   w_state_nxt;
  logic [IDX_W-1:0]                         r_index;
  logic [OAM_DATA_SIZE-1:0]                 r_obj;
  logic [VRAM_DATA_SIZE-1:0]                r_pix;
  logic [DISPLAY_WIDTH-1:0][PIXEL_BITS-1:0] r_line_buffer;
  logic [DISPLAY_WIDTH-1:0]                 r_line_prio;

  logic [OAM_ADDR_SIZE:0]   w_entry;
  logic                     w_at_end;
  logic [7:0]               w_ref;
  logic [9:0]               w_xpos;
  logic [9:0]               w_ypos;
  logic                     w_prio;
  logic                     w_xflip;
  logic                     w_yflip;
  logic                     w_enable;
  logic [10:0]              w_row_full;
  logic [ROW_W-1:0]         w_row;
  logic [ROW_W-1:0]         w_vrow;
  logic                     w_skip;

  logic [SPRITE_WIDTH-1:0][10:0]           w_x;
  logic [SPRITE_WIDTH-1:0][PIXEL_BITS-1:0] w_px;
  logic [SPRITE_WIDTH-1:0]                 w_wr;

  assign w_entry  = second_array[r_index[SEL_W-1:0]];
  assign w_at_end = (r_index == IDX_W'(SECOND_ARRAY_SIZE));

  assign w_ref    = r_obj[7:0];
  assign w_xpos   = r_obj[17:8];
  assign w_ypos   = r_obj[27:18];
  assign w_prio   = r_obj[28];
  assign w_xflip  = r_obj[29];
  assign w_yflip  = r_obj[30];
  assign w_enable = r_obj[31];

  // Sprite height is a power of two, so H-1-row is the bitwise inverse of row.
  assign w_row_full = 11'(line_number) - 11'(w_ypos);
  assign w_row      = w_row_full[ROW_W-1:0];
  assign w_vrow     = w_yflip ? ~w_row : w_row;
  assign w_skip     = !w_enable || (11'(line_number) < 11'(w_ypos)) || (w_row_full[10:ROW_W] != '0);

  always_comb begin
    w_x  = '0;
    w_px = '0;
    w_wr = '0;
    for (int i = 0; i < SPRITE_WIDTH; i++) begin
      w_x[i]  = 11'(w_xpos) + 11'(i);
      w_px[i] = r_pix[(w_xflip ? (SPRITE_WIDTH - 1 - i) : i) * PIXEL_BITS +: PIXEL_BITS];
      // First owner wins: only transparent (zero) buffer pixels accept new data.
      w_wr[i] = (w_x[i] < 11'(DISPLAY_WIDTH)) && (w_px[i] != '0) &&
                (r_line_buffer[w_x[i][XW-1:0]] == '0);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    oam_rd      = 1'b0;
    oam_a       = '0;
    vram_rd     = 1'b0;
    vram_a      = '0;
    case (r_state)
      S_IDLE:     if (start) w_state_nxt = S_CLEAR;
      S_CLEAR:    w_state_nxt = S_OAM_REQ;
      S_OAM_REQ: begin
        if (w_at_end || !w_entry[0]) begin
          w_state_nxt = S_DONE;
        end else begin
          oam_rd      = 1'b1;
          oam_a       = w_entry[OAM_ADDR_SIZE:1];
          w_state_nxt = S_OAM_LAT;
        end
      end
      S_OAM_LAT:  w_state_nxt = S_VRAM_REQ;
      S_VRAM_REQ: begin
        if (w_skip) begin
          w_state_nxt = S_OAM_REQ;
        end else begin
          vram_rd     = 1'b1;
          vram_a      = VRAM_ADDR_SIZE'({w_ref, w_vrow});
          w_state_nxt = S_VRAM_LAT;
        end
      end
      S_VRAM_LAT: w_state_nxt = S_DRAW;
      S_DRAW:     w_state_nxt = S_OAM_REQ;
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_index       <= '0;
      r_obj         <= '0;
      r_pix         <= '0;
      r_line_buffer <= '0;
      r_line_prio   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_CLEAR: begin
          r_index       <= '0;
          r_line_buffer <= '0;
          r_line_prio   <= '0;
        end
        S_OAM_LAT:  r_obj <= oam_d;
        S_VRAM_REQ: if (w_skip) r_index <= r_index + 1'b1;
        S_VRAM_LAT: r_pix <= vram_d;
        S_DRAW: begin
          for (int i = 0; i < SPRITE_WIDTH; i++) begin
            if (w_wr[i]) begin
              r_line_buffer[w_x[i][XW-1:0]] <= w_px[i];
              r_line_prio[w_x[i][XW-1:0]]   <= w_prio;
            end
          end
          r_index <= r_index + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign line_buffer = r_line_buffer;
  assign line_prio   = r_line_prio;

endmodule

// File: tb/tb_sprite_line_renderer.sv
// tb/tb_sprite_line_renderer.sv - scoreboard bench for sprite_line_renderer
module tb_sprite_line_renderer;

  typedef logic [599:0][7:0] buf_t;
  typedef logic [599:0]      prio_t;
  typedef struct {
    int    lat;
    int    noam;
    int    nvram;
    buf_t  bufv;
    prio_t prio;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              busy;
  logic              done;
  logic [31:0][8:0]  sa;
  logic [8:0]        line_number;
  logic              oam_rd;
  logic [7:0]        oam_a;
  logic [31:0]       oam_d;
  logic              vram_rd;
  logic [11:0]       vram_a;
  logic [127:0]      vram_d;
  buf_t              line_buffer;
  prio_t             line_prio;

  logic [31:0]  oam_mem  [256];
  logic [127:0] vram_mem [4096];

  exp_t        exp_q[$];
  logic [11:0] vq[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc = 0;
  int ndone = 0;
  int m_noam = 0;
  int m_nvram = 0;
  exp_t  m_e;
  buf_t  b;
  prio_t p;

  sprite_line_renderer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .second_array(sa), .line_number(line_number),
    .oam_rd(oam_rd), .oam_a(oam_a), .oam_d(oam_d),
    .vram_rd(vram_rd), .vram_a(vram_a), .vram_d(vram_d),
    .line_buffer(line_buffer), .line_prio(line_prio)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (oam_rd) oam_d <= oam_mem[oam_a];
    if (vram_rd) vram_d <= vram_mem[vram_a];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] obj(input int rf, input int x, input int y,
                                      input int pr, input int xf, input int yf, input int en);
    logic [31:0] w;
    w = {1'(en), 1'(yf), 1'(xf), 1'(pr), 10'(y), 10'(x), 8'(rf)};
    return w;
  endfunction

  // Monitor: pops expectations whenever the DUT presents vram_rd or done.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_noam  = 0;
      m_nvram = 0;
    end else begin
      if (oam_rd) m_noam++;
      else chk("oam_a_idle", 64'(oam_a), 64'd0);
      if (vram_rd) begin
        m_nvram++;
        if (vq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_vram_rd actual=%0h expected=none", vram_a);
        end else chk("vram_a", 64'(vram_a), 64'(vq.pop_front()));
      end else chk("vram_a_idle", 64'(vram_a), 64'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          int idx;
          m_e = exp_q.pop_front();
          chk("latency", 64'(cyc - acc), 64'(m_e.lat));
          chk("oam_reads", 64'(m_noam), 64'(m_e.noam));
          chk("vram_reads", 64'(m_nvram), 64'(m_e.nvram));
          idx = -1;
          for (int k = 0; k < 600; k++)
            if (idx < 0 && (line_buffer[k] !== m_e.bufv[k] || line_prio[k] !== m_e.prio[k])) idx = k;
          checks++;
          if (idx >= 0) begin
            failures++;
            $display("FAIL line_pixel[%0d] actual=%0h/p%0b expected=%0h/p%0b", idx,
                     line_buffer[idx], line_prio[idx], m_e.bufv[idx], m_e.prio[idx]);
          end
        end
        ndone++;
        m_noam  = 0;
        m_nvram = 0;
      end
    end
  end

  task automatic run(input int lat, input int noam, input int nvram, input bit extra_start);
    exp_t e;
    int   n0;
    e.lat = lat; e.noam = noam; e.nvram = nvram; e.bufv = b; e.prio = p;
    exp_q.push_back(e);
    n0 = ndone;
    @(negedge clk);
    start = 1'b1;
    acc   = cyc;
    @(negedge clk);
    start = 1'b0;
    if (extra_start) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int k = 0; k < 300 && ndone == n0; k++) @(negedge clk);
    if (ndone == n0) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=none expected=done");
      void'(exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  initial begin
    int n0;
    rst_n = 1'b0; start = 1'b0; sa = '0; line_number = 9'd45;
    for (int k = 0; k < 256; k++) oam_mem[k] = '0;
    for (int k = 0; k < 4096; k++) vram_mem[k] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_oam_rd", 64'(oam_rd), 64'd0);
    chk("reset_vram_rd", 64'(vram_rd), 64'd0);
    chk("reset_buffer_zero", 64'(line_buffer == '0), 64'd1);
    chk("reset_prio_zero", 64'(line_prio == '0), 64'd1);

    // Empty list
    b = '0; p = '0;
    run(3, 0, 0, 1'b0);

    // Single sprite, row 5
    oam_mem[3] = obj(8'h21, 100, 40, 1, 0, 0, 1);
    for (int c = 0; c < 16; c++) vram_mem[12'h215][c*8 +: 8] = 8'(c + 1);
    sa[0] = {8'd3, 1'b1};
    b = '0; p = '0;
    for (int i = 0; i < 16; i++) begin b[100+i] = 8'(i + 1); p[100+i] = 1'b1; end
    vq.push_back(12'h215);
    run(8, 1, 1, 1'b0);

    // x and y flip: row 5 becomes row 10, pixels reversed
    oam_mem[4] = obj(8'h22, 100, 40, 0, 1, 1, 1);
    for (int c = 0; c < 16; c++) vram_mem[12'h22A][c*8 +: 8] = 8'(c + 1);
    sa[0] = {8'd4, 1'b1};
    b = '0; p = '0;
    for (int i = 0; i < 16; i++) b[100+i] = 8'(16 - i);
    vq.push_back(12'h22A);
    run(8, 1, 1, 1'b0);

    // Overlap: entry0 owns columns 8..15, entry1 fills transparent 0..7; stray start ignored
    oam_mem[5] = obj(8'h30, 10, 40, 0, 0, 0, 1);
    oam_mem[6] = obj(8'h31, 10, 40, 1, 0, 0, 1);
    for (int c = 0; c < 16; c++) begin
      vram_mem[12'h305][c*8 +: 8] = (c < 8) ? 8'd0 : 8'd3;
      vram_mem[12'h315][c*8 +: 8] = 8'd7;
    end
    sa[0] = {8'd5, 1'b1}; sa[1] = {8'd6, 1'b1};
    b = '0; p = '0;
    for (int i = 0; i < 8; i++) begin b[10+i] = 8'd7; p[10+i] = 1'b1; b[18+i] = 8'd3; end
    vq.push_back(12'h305); vq.push_back(12'h315);
    run(13, 2, 2, 1'b1);

    // Right-edge clip
    oam_mem[7] = obj(8'h40, 590, 40, 1, 0, 0, 1);
    for (int c = 0; c < 16; c++) vram_mem[12'h405][c*8 +: 8] = 8'(8'h80 + c);
    sa[0] = {8'd7, 1'b1}; sa[1] = '0;
    b = '0; p = '0;
    for (int i = 0; i < 10; i++) begin b[590+i] = 8'(8'h80 + i); p[590+i] = 1'b1; end
    vq.push_back(12'h405);
    run(8, 1, 1, 1'b0);

    // Skips: disabled, below line, row 16 just out of range; then a drawn sprite
    oam_mem[8]  = obj(8'h50, 100, 45, 1, 0, 0, 0);
    oam_mem[9]  = obj(8'h51, 100, 50, 1, 0, 0, 1);
    oam_mem[10] = obj(8'h52, 100, 29, 1, 0, 0, 1);
    sa[0] = {8'd8, 1'b1}; sa[1] = {8'd9, 1'b1}; sa[2] = {8'd10, 1'b1}; sa[3] = {8'd3, 1'b1};
    b = '0; p = '0;
    for (int i = 0; i < 16; i++) begin b[100+i] = 8'(i + 1); p[100+i] = 1'b1; end
    vq.push_back(12'h215);
    run(17, 4, 1, 1'b0);

    // Last row of sprite (row 15)
    oam_mem[11] = obj(8'h60, 200, 30, 0, 0, 0, 1);
    for (int c = 0; c < 16; c++) vram_mem[12'h60F][c*8 +: 8] = 8'h55;
    sa = '0; sa[0] = {8'd11, 1'b1};
    b = '0; p = '0;
    for (int i = 0; i < 16; i++) b[200+i] = 8'h55;
    vq.push_back(12'h60F);
    run(8, 1, 1, 1'b0);

    // Full array of disabled objects: ends on the index limit
    for (int k = 0; k < 32; k++) sa[k] = {8'd8, 1'b1};
    b = '0; p = '0;
    run(99, 32, 0, 1'b0);

    // Reset during DRAW: immediate abort, no done
    sa = '0; sa[0] = {8'd3, 1'b1};
    vq.push_back(12'h215);
    n0 = ndone;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 50 && !vram_rd; k++) @(negedge clk);
    chk("abort_saw_vram_rd", 64'(vram_rd), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_oam_rd", 64'(oam_rd), 64'd0);
    chk("abort_vram_rd", 64'(vram_rd), 64'd0);
    repeat (3) @(negedge clk);
    chk("abort_buffer_zero", 64'(line_buffer == '0), 64'd1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_done", 64'(ndone - n0), 64'd0);

    // Recovery run after abort
    b = '0; p = '0;
    for (int i = 0; i < 16; i++) begin b[100+i] = 8'(i + 1); p[100+i] = 1'b1; end
    vq.push_back(12'h215);
    run(8, 1, 1, 1'b0);

    chk("expect_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("vram_queue_drained", 64'(vq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
